// File: rtl/tilemap_pkg.sv
// Shared types and constants for the tilemap RAM write path.
package tilemap_pkg;

    localparam int TM_ENTRIES      = 256;
    localparam int ACTIVE_ROWS_DEF = 128;
    localparam int ACTIVE_COLS_DEF = 128;

    typedef logic [7:0] tm_addr_t;
    typedef logic [7:0] tm_entry_t;

    typedef struct packed {
        tm_addr_t  addr;
        tm_entry_t data;
    } tm_wr_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_EMPTY = 2'd1,
        FILL       = 2'd2
    } tmw_state_t;

endpackage

// File: rtl/tm_write_fifo.sv
// Small synchronous FIFO buffering host tilemap writes until the beam leaves
// the active region.
module tm_write_fifo
    import tilemap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  tm_wr_t                 din,
    output tm_wr_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    tm_wr_t        mem_q [DEPTH];
    tm_wr_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is nonzero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tilemap_writer.sv
// Tilemap RAM write agent: buffers host writes and runs a clear/fill engine,
// committing to the RAM only while the beam is outside the active region.
//
//  state      | meaning
//  IDLE       | drain host FIFO during blanking; accept host writes and fill_start
//  WAIT_EMPTY | fill requested; host blocked until the FIFO has drained
//  FILL       | write latched fill value to entries 0..255, one per blanking cycle
module tilemap_writer
    import tilemap_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACTIVE_ROWS = ACTIVE_ROWS_DEF,
    parameter int ACTIVE_COLS = ACTIVE_COLS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] row,
    input  logic [9:0] col,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       fill_start,
    input  logic [7:0] fill_value,
    output logic       fill_busy,
    output logic       fill_done,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_din
);
    localparam logic [9:0]  ROW_LIM   = 10'(ACTIVE_ROWS);
    localparam logic [10:0] COL_LIM   = 11'(ACTIVE_COLS);
    localparam tm_addr_t    LAST_ADDR = tm_addr_t'(TM_ENTRIES - 1);

    tmw_state_t state_q, state_d;
    logic       win_q, win_d;
    tm_entry_t  fill_val_q, fill_val_d;
    tm_addr_t   fill_cnt_q, fill_cnt_d;
    logic       ram_we_q, ram_we_d;
    tm_addr_t   ram_addr_q, ram_addr_d;
    tm_entry_t  ram_din_q, ram_din_d;
    logic       fill_done_q, fill_done_d;

    logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    tm_wr_t                        fifo_head;

    // Ready depends only on registered state, never on wr_valid.
    assign wr_ready  = !fifo_full && (state_q == IDLE);
    assign fifo_push = wr_valid && wr_ready;
    assign fill_busy = (state_q != IDLE);
    assign fill_done = fill_done_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

    tm_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ('{addr: wr_addr, data: wr_data}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = !(({1'b0, row} < ROW_LIM) && ({1'b0, col} < COL_LIM));
        fill_val_d  = fill_val_q;
        fill_cnt_d  = fill_cnt_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        fill_done_d = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                fifo_pop = win_q && !fifo_empty;
                if (fill_start) begin
                    state_d    = WAIT_EMPTY;
                    fill_val_d = fill_value;
                end
            end
            WAIT_EMPTY: begin
                if (fifo_count == '0) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                end else begin
                    fifo_pop = win_q;
                end
            end
            FILL: begin
                if (win_q) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = fill_cnt_q;
                    ram_din_d  = fill_val_q;
                    fill_cnt_d = fill_cnt_q + 8'd1;
                    if (fill_cnt_q == LAST_ADDR) begin
                        state_d     = IDLE;
                        fill_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fifo_pop) begin
            ram_we_d   = 1'b1;
            ram_addr_d = fifo_head.addr;
            ram_din_d  = fifo_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= 1'b0;
            fill_val_q  <= '0;
            fill_cnt_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            fill_val_q  <= fill_val_d;
            fill_cnt_q  <= fill_cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            fill_done_q <= fill_done_d;
        end
    end

endmodule

// File: tb/tb_tilemap_writer.sv
// Bench for tilemap_writer: an expected-write queue model checked every cycle,
// plus directed scenarios with hand-computed timing and addresses.
module tb_tilemap_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] row;
    logic [9:0] col;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr, wr_data;
    logic       fill_start;
    logic [7:0] fill_value;
    logic       fill_busy, fill_done;
    logic       ram_we;
    logic [7:0] ram_addr, ram_din;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tilemap_writer dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: every accepted host write and every accepted fill (256 entries)
    // enters this queue; the RAM port must drain it in order, only when the
    // beam was outside the active region two cycles earlier.
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    bit         fill_m_busy = 1'b0;
    bit         rst_prev    = 1'b1;
    bit         open_h1     = 1'b0;
    bit         open_h2     = 1'b0;
    bit         open_now;
    logic [7:0] last_addr   = 8'h00;
    logic [7:0] last_din    = 8'h00;
    int         n_writes    = 0;
    int         n_done      = 0;

    always @(negedge clk) begin
        open_now = !(row < 128 && col < 128);
        if (rst_prev) begin
            check("reset_ram_we",    ram_we,    0);
            check("reset_fill_busy", fill_busy, 0);
            check("reset_fill_done", fill_done, 0);
            check("reset_wr_ready",  wr_ready,  1);
            check("reset_ram_addr",  ram_addr,  0);
            check("reset_ram_din",   ram_din,   0);
            last_addr = 8'h00;
            last_din  = 8'h00;
        end else begin
            if (ram_we) begin
                n_writes++;
                check("write_in_window", open_h2, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0h din %0h expected no write", ram_addr, ram_din);
                end else begin
                    cur = exp_q.pop_front();
                    check("ram_addr", ram_addr, cur.addr);
                    check("ram_din",  ram_din,  cur.data);
                    check("fill_done_on_last", fill_done, cur.last);
                    if (cur.last) fill_m_busy = 1'b0;
                end
                last_addr = ram_addr;
                last_din  = ram_din;
            end else begin
                check("done_without_write", fill_done, 0);
                check("ram_addr_hold", ram_addr, last_addr);
                check("ram_din_hold",  ram_din,  last_din);
            end
            if (fill_done) n_done++;
        end
        if (rst) begin
            exp_q.delete();
            fill_m_busy = 1'b0;
        end else begin
            if (wr_valid && wr_ready) exp_q.push_back('{wr_addr, wr_data, 1'b0});
            if (fill_start && !fill_m_busy) begin
                fill_m_busy = 1'b1;
                for (int i = 0; i < 256; i++) exp_q.push_back('{i[7:0], fill_value, (i == 255)});
            end
        end
        rst_prev = rst;
        open_h2  = open_h1;
        open_h1  = open_now;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        bit acc = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        check("host_write_accepted", acc, 1);
    endtask

    task automatic pulse_fill(input logic [7:0] v);
        fill_start = 1'b1;
        fill_value = v;
        tick();
        fill_start = 1'b0;
        fill_value = 8'h00;
    endtask

    task automatic wait_write_addr(input logic [7:0] a, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < 600 && !hit; k++) begin
            @(negedge clk);
            hit = ram_we && (ram_addr == a);
        end
        check(name, hit, 1);
    endtask

    task automatic wait_done(input string name);
        bit hit = 1'b0;
        for (int k = 0; k < 600 && !hit; k++) begin
            @(negedge clk);
            hit = fill_done;
        end
        check(name, hit, 1);
        if (hit) check({name, "_busy_falls"}, fill_busy, 0);
    endtask

    logic       we_s   [6];
    logic [7:0] addr_s [6];
    logic       rdy_s  [6];
    int         nw0, nd0;

    initial begin
        row = 9'd200; col = 10'd0;
        wr_valid = 1'b1; wr_addr = 8'h55; wr_data = 8'h66;
        fill_start = 1'b0; fill_value = 8'h00;

        // 1: reset with wr_valid high and the window open
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; wr_valid = 1'b0; row = 9'd10; col = 10'd20;
        @(negedge clk);
        check("t1_wr_ready", wr_ready, 1);
        check("t1_ram_we",   ram_we,   0);
        check("t1_busy",     fill_busy, 0);
        repeat (4) tick();
        check("t1_no_writes", n_writes, 0);

        // 2: window gating
        host_write(8'h12, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_gated", ram_we, 0);
        end
        tick();
        col = 10'd200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we_s[i] = ram_we; addr_s[i] = ram_addr;
        end
        check("t2_we0", we_s[0], 0);
        check("t2_we1", we_s[1], 0);
        check("t2_we2", we_s[2], 1);
        check("t2_addr", addr_s[2], 8'h12);
        check("t2_din", ram_din, 8'hA5);
        tick();
        col = 10'd20;
        repeat (3) tick();

        // 3: full FIFO, then drain on consecutive cycles
        for (int i = 0; i < 4; i++) host_write(8'(8'hA0 + i), 8'(8'h10 + i));
        @(negedge clk);
        check("t3_full_not_ready", wr_ready, 0);
        tick();
        col = 10'd200;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we_s[i] = ram_we; addr_s[i] = ram_addr; rdy_s[i] = wr_ready;
        end
        check("t3_we_c0", we_s[0], 0);
        check("t3_we_c1", we_s[1], 0);
        check("t3_rdy_c1", rdy_s[1], 0);
        check("t3_rdy_c2", rdy_s[2], 1);
        for (int i = 2; i < 6; i++) begin
            check("t3_we", we_s[i], 1);
            check("t3_order", addr_s[i], 8'(8'hA0 + i - 2));
        end
        tick();
        col = 10'd20;
        repeat (3) tick();

        // 4: fill queued behind two pending host writes
        host_write(8'h01, 8'h11);
        host_write(8'h02, 8'h22);
        nw0 = n_writes; nd0 = n_done;
        pulse_fill(8'h3C);
        @(negedge clk);
        check("t4_busy", fill_busy, 1);
        check("t4_blocked", wr_ready, 0);
        tick();
        col = 10'd200;
        wait_done("t4_done");
        tick();
        check("t4_total_writes", n_writes - nw0, 258);
        check("t4_done_once", n_done - nd0, 1);

        // 5: window closes mid-fill, then reopens
        nw0 = n_writes; nd0 = n_done;
        pulse_fill(8'h5A);
        wait_write_addr(8'h40, "t5_reach_40");
        tick();
        col = 10'd20;
        fill_start = 1'b1; fill_value = 8'hEE;
        tick();
        fill_start = 1'b0; fill_value = 8'h00;
        repeat (9) tick();
        check("t5_paused_at", ram_addr, 8'h42);
        check("t5_paused_count", n_writes - nw0, 8'h43);
        check("t5_busy_held", fill_busy, 1);
        col = 10'd200;
        wait_write_addr(8'h43, "t5_resume");
        check("t5_resume_din", ram_din, 8'h5A);
        wait_done("t5_done");
        tick();
        check("t5_total_writes", n_writes - nw0, 256);
        check("t5_done_once", n_done - nd0, 1);

        // 6: reset mid-fill, then a fresh fill from 0
        pulse_fill(8'h77);
        wait_write_addr(8'h80, "t6_reach_80");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_we", ram_we, 0);
        check("t6_rst_busy", fill_busy, 0);
        tick();
        nw0 = n_writes;
        repeat (20) tick();
        check("t6_no_writes", n_writes - nw0, 0);
        pulse_fill(8'h99);
        wait_write_addr(8'h00, "t6_restart_addr0");
        check("t6_restart_din", ram_din, 8'h99);
        wait_done("t6_done");
        tick();
        check("t6_model_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
